// File: rtl/serial_add_scheduler_if.sv
// serial_add_scheduler_if: request/response bundle between operand producers, the scheduler and the result consumer
//   req_valid/req_ready : per-requester handshake, req_ready one-hot
//   req_a/req_b         : packed operands, requester i at [i*WIDTH +: WIDTH]
//   resp_*              : result channel (valid/ready, id, sum, carry-out)
//   busy                : scheduler not idle
interface serial_add_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*WIDTH-1:0]   req_a;
    logic [NUM_REQ*WIDTH-1:0]   req_b;
    logic                       resp_valid;
    logic                       resp_ready;
    logic [$clog2(NUM_REQ)-1:0] resp_id;
    logic [WIDTH-1:0]           resp_sum;
    logic                       resp_cout;
    logic                       busy;
    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_sum, resp_cout, busy
    );
    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_sum, resp_cout, busy
    );
endinterface

// File: rtl/serial_add_scheduler.sv
// serial_add_scheduler: round-robin sharing of one LSB-first bit-serial adder among NUM_REQ requesters
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : serial_add_scheduler_if.slave (requests in, results out)
module serial_add_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input logic                  clk,
    input logic                  rst,
    serial_add_scheduler_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q;
    logic [IW-1:0]    ptr_q, id_q, gnt_idx;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q, cout_q, vld_q, gnt_vld, s_bit, c_nxt;
    // Scan from the highest offset down so the closest valid requester after ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                gnt_vld = 1'b1;
                gnt_idx = IW'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end
    assign s_bit          = a_q[0] ^ b_q[0] ^ c_q;
    assign c_nxt          = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    assign bus.req_ready  = (state_q == IDLE && gnt_vld) ? NUM_REQ'(1) << gnt_idx : '0;
    assign bus.resp_valid = vld_q;
    assign bus.resp_id    = id_q;
    assign bus.resp_sum   = s_q;
    assign bus.resp_cout  = cout_q;
    assign bus.busy       = state_q != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (gnt_vld) begin
                    a_q     <= bus.req_a[int'(gnt_idx)*WIDTH +: WIDTH];
                    b_q     <= bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH];
                    c_q     <= 1'b0;
                    cnt_q   <= '0;
                    id_q    <= gnt_idx;
                    ptr_q   <= IW'((int'(gnt_idx) + 1) % NUM_REQ);
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    c_q   <= c_nxt;
                    s_q   <= (s_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= DONE;
                        vld_q   <= 1'b1;
                        cout_q  <= c_nxt;
                    end
                end
                DONE: if (bus.resp_ready) begin
                    vld_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_scheduler.sv
// tb_serial_add_scheduler: directed checks of arbitration, serial sums, latency, backpressure and reset
module tb_serial_add_scheduler;
    localparam int N = 4;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    serial_add_scheduler_if #(.NUM_REQ(N), .WIDTH(W)) bus();
    serial_add_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic wait_resp(input int start, output int lat);
        lat = start;
        while (bus.resp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic do_op(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] es, input logic ec);
        int lat;
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_valid = N'(1) << i;
        #1 chk("grant", 32'(bus.req_ready), 32'(1) << i);
        @(negedge clk);
        bus.req_valid = '0;
        wait_resp(1, lat);
        chk("latency", lat, 9);
        chk("sum", 32'(bus.resp_sum), 32'(es));
        chk("cout", 32'(bus.resp_cout), 32'(ec));
        chk("id", 32'(bus.resp_id), i);
        @(negedge clk);
        chk("post_valid", 32'(bus.resp_valid), 0);
        chk("post_busy", 32'(bus.busy), 0);
    endtask
    initial begin
        logic [7:0] es4 [4];
        logic       ec4 [4];
        int lat, w, prev;
        es4 = '{8'h11, 8'h22, 8'h33, 8'h00};
        ec4 = '{1'b0, 1'b0, 1'b0, 1'b1};
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_valid", 32'(bus.resp_valid), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_sum", 32'(bus.resp_sum), 0);
        chk("rst_id", 32'(bus.resp_id), 0);
        chk("rst_cout", 32'(bus.resp_cout), 0);
        rst = 1'b0;
        // basic sums, ptr ends at 0
        do_op(0, 8'h35, 8'h4A, 8'h7F, 1'b0);
        do_op(1, 8'hFF, 8'h01, 8'h00, 1'b1);
        do_op(3, 8'hFF, 8'hFF, 8'hFE, 1'b1);
        // all requesters valid: rotation 0,1,2,3,0 every 10 cycles
        bus.req_a = {8'h40, 8'h30, 8'h20, 8'h10};
        bus.req_b = {8'hC0, 8'h03, 8'h02, 8'h01};
        bus.req_valid = '1;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            #1;
            while (bus.req_ready == '0 && w < 20) begin
                @(negedge clk);
                #1;
                w++;
            end
            chk("rr_grant", 32'(bus.req_ready), 32'(1) << (k % 4));
            if (k > 0) chk("rr_spacing", cyc - prev, 10);
            prev = cyc;
            @(negedge clk);
            wait_resp(1, lat);
            chk("rr_id", 32'(bus.resp_id), k % 4);
            chk("rr_sum", 32'(bus.resp_sum), 32'(es4[k % 4]));
            chk("rr_cout", 32'(bus.resp_cout), 32'(ec4[k % 4]));
            if (k == 4) bus.req_valid = '0;
            @(negedge clk);
        end
        // backpressure: ptr=1, req2 served and held 5 cycles while req0 waits
        bus.resp_ready = 1'b0;
        bus.req_a[2*W +: W] = 8'h7E;
        bus.req_b[2*W +: W] = 8'h03;
        bus.req_valid = 4'b0100;
        #1 chk("bp_grant", 32'(bus.req_ready), 32'h4);
        @(negedge clk);
        bus.req_valid = 4'b0001;
        wait_resp(1, lat);
        chk("bp_latency", lat, 9);
        for (int j = 0; j < 5; j++) begin
            chk("bp_valid", 32'(bus.resp_valid), 1);
            chk("bp_sum", 32'(bus.resp_sum), 32'h81);
            chk("bp_id", 32'(bus.resp_id), 2);
            chk("bp_ready", 32'(bus.req_ready), 0);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_drop", 32'(bus.resp_valid), 0);
        chk("bp_idle", 32'(bus.busy), 0);
        chk("bp_next", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = '0;
        wait_resp(1, lat);
        chk("bp_id0", 32'(bus.resp_id), 0);
        chk("bp_sum0", 32'(bus.resp_sum), 32'h11);
        @(negedge clk);
        // skip non-valid requesters from ptr=2; operand change after accept ignored
        do_op(1, 8'h99, 8'h99, 8'h32, 1'b1);
        bus.req_a[3*W +: W] = 8'h12;
        bus.req_b[3*W +: W] = 8'h34;
        bus.req_a[0 +: W] = 8'h80;
        bus.req_b[0 +: W] = 8'h80;
        bus.req_valid = 4'b1001;
        #1 chk("skip_grant", 32'(bus.req_ready), 32'h8);
        @(negedge clk);
        bus.req_a[3*W +: W] = 8'hFF;
        bus.req_valid = 4'b0001;
        wait_resp(1, lat);
        chk("skip_id3", 32'(bus.resp_id), 3);
        chk("skip_sum3", 32'(bus.resp_sum), 32'h46);
        chk("skip_cout3", 32'(bus.resp_cout), 0);
        @(negedge clk);
        chk("skip_grant0", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = '0;
        wait_resp(1, lat);
        chk("skip_id0", 32'(bus.resp_id), 0);
        chk("skip_sum0", 32'(bus.resp_sum), 32'h00);
        chk("skip_cout0", 32'(bus.resp_cout), 1);
        @(negedge clk);
        // reset in the middle of SHIFT drops the job and clears ptr
        bus.req_a[W +: W] = 8'h0F;
        bus.req_b[W +: W] = 8'h01;
        bus.req_valid = 4'b0010;
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mr_busy", 32'(bus.busy), 0);
        chk("mr_valid", 32'(bus.resp_valid), 0);
        chk("mr_sum", 32'(bus.resp_sum), 0);
        chk("mr_id", 32'(bus.resp_id), 0);
        chk("mr_cout", 32'(bus.resp_cout), 0);
        rst = 1'b0;
        bus.req_valid = '1;
        #1 chk("mr_ptr", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = '0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
